// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - score, high score and lives controller with event FIFO and digit-serial BCD adder
// Optional SCORE_HEX_EN adds registered active-low seven-segment outputs for the score.

module score_keeper #(
  parameter int DIGITS       = 6,
  parameter int START_LIVES  = 3,
  parameter int MAX_LIVES    = 5,
  parameter int EXTRA_LIFE_K = 10,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  pellet,
  input  logic                  power_pellet,
  input  logic [3:0]            ghost_eaten,
  input  logic                  pacman_death,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   high_bcd,
  output logic [2:0]            lives,
  output logic [1:0]            combo,
  output logic                  game_over,
  output logic                  busy,
  output logic                  dropped
`ifdef SCORE_HEX_EN
  ,
  output logic [7*DIGITS-1:0]   hex
`endif
);

  localparam int W  = 4 * DIGITS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(DIGITS + 1);

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Event codes: 0 pellet, 1 power, 2..5 ghost worth 200 << (code-2).
  function automatic logic [W-1:0] addend_bcd(input logic [2:0] code);
    logic [W-1:0] r;
    r = '0;
    case (code)
      3'd0:    r[15:0] = 16'h0010;
      3'd1:    r[15:0] = 16'h0050;
      3'd2:    r[15:0] = 16'h0200;
      3'd3:    r[15:0] = 16'h0400;
      3'd4:    r[15:0] = 16'h0800;
      3'd5:    r[15:0] = 16'h1600;
      default: r = '0;
    endcase
    return r;
  endfunction

  localparam logic [W-1:0]  THRESH    = to_bcd(EXTRA_LIFE_K * 1000);
  localparam logic [W-1:0]  ALL_NINES = {DIGITS{4'h9}};
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_COMMIT} state_t;

  logic [5:0]    src_q, src_d, flag_q, flag_d, rise, events, push_oh;
  logic          death_q, death_d, death_rise;
  logic [2:0]    gcnt_q, gcnt_d, push_code;
  logic [1:0]    gk;
  logic [2:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push, pop, commit, extra;
  state_t        state_q, state_d;
  logic [DW-1:0] dig_q, dig_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  sum_q, sum_d, addend_q, addend_d, score_q, score_d;
  logic [W-1:0]  high_q, high_d, new_score, high_cand;
  logic [2:0]    lives_q, lives_d;
  logic          over_q, over_d, xlife_q, xlife_d, dropped_q, dropped_d;
  logic [4:0]    dsum;

  assign rise       = {pellet, power_pellet, ghost_eaten} & ~src_q;
  assign events     = over_q ? 6'b0 : rise;
  assign death_rise = pacman_death & ~death_q;

  // Lowest-index flag wins: ghost0..3, then power, then pellet.
  always_comb begin
    push_oh = 6'b0;
    for (int i = 5; i >= 0; i--) begin
      if (flag_q[i]) push_oh = 6'b1 << i;
    end
    push = (|flag_q) && (cnt_q != FULL_CNT);
    gk   = (gcnt_q >= 3'd3) ? 2'd3 : gcnt_q[1:0];
    if (|push_oh[3:0])   push_code = 3'd2 + {1'b0, gk};
    else if (push_oh[4]) push_code = 3'd1;
    else                 push_code = 3'd0;
  end

  always_comb begin
    src_d     = {pellet, power_pellet, ghost_eaten};
    death_d   = pacman_death;
    flag_d    = (flag_q & ~(push ? push_oh : 6'b0)) | events;
    dropped_d = dropped_q | (|(events & flag_q));
    gcnt_d    = gcnt_q;
    if (push && (|push_oh[3:0]) && gcnt_q != 3'd4) gcnt_d = gcnt_q + 3'd1;
    if (push && push_oh[4])                        gcnt_d = 3'd0;

    pop    = (state_q == S_IDLE) && (cnt_q != '0);
    wptr_d = push ? wptr_q + PTR_ONE : wptr_q;
    rptr_d = pop ? rptr_q + PTR_ONE : rptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    state_d  = state_q;
    dig_d    = dig_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    addend_d = addend_q;
    dsum     = 5'd0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d  = S_ADD;
          dig_d    = '0;
          carry_d  = 1'b0;
          sum_d    = score_q;
          addend_d = addend_bcd(mem_q[rptr_q]);
        end
      end
      S_ADD: begin
        // Sum rotates right one digit per cycle, so after DIGITS cycles it is back in place.
        dsum = {1'b0, sum_q[3:0]} + {1'b0, addend_q[3:0]} + {4'b0, carry_q};
        if (dsum > 5'd9) begin
          sum_d   = {4'(dsum - 5'd10), sum_q[W-1:4]};
          carry_d = 1'b1;
        end else begin
          sum_d   = {dsum[3:0], sum_q[W-1:4]};
          carry_d = 1'b0;
        end
        addend_d = {4'h0, addend_q[W-1:4]};
        dig_d    = dig_q + DW'(1);
        if (dig_q == DW'(DIGITS - 1)) state_d = S_COMMIT;
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    commit    = (state_q == S_COMMIT);
    new_score = carry_q ? ALL_NINES : sum_q;
    score_d   = commit ? new_score : score_q;
    extra     = commit && !xlife_q && (new_score >= THRESH);
    xlife_d   = xlife_q | extra;

    lives_d = lives_q;
    case ({extra, death_rise})
      2'b10:   if (lives_q < 3'(MAX_LIVES)) lives_d = lives_q + 3'd1;
      2'b01:   if (lives_q != 3'd0)         lives_d = lives_q - 3'd1;
      default: lives_d = lives_q;
    endcase

    over_d    = over_q | (lives_q == 3'd0);
    high_d    = high_q;
    high_cand = commit ? new_score : score_q;
    if (((lives_q == 3'd0 && !over_q) || (commit && over_q)) && high_cand > high_q)
      high_d = high_cand;

    if (clear) begin
      src_d     = '0;
      death_d   = 1'b0;
      flag_d    = '0;
      dropped_d = 1'b0;
      gcnt_d    = '0;
      wptr_d    = '0;
      rptr_d    = '0;
      cnt_d     = '0;
      state_d   = S_IDLE;
      dig_d     = '0;
      carry_d   = 1'b0;
      sum_d     = '0;
      addend_d  = '0;
      score_d   = '0;
      xlife_d   = 1'b0;
      lives_d   = 3'(START_LIVES);
      over_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_code;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q     <= '0;
      death_q   <= 1'b0;
      flag_q    <= '0;
      dropped_q <= 1'b0;
      gcnt_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      state_q   <= S_IDLE;
      dig_q     <= '0;
      carry_q   <= 1'b0;
      sum_q     <= '0;
      addend_q  <= '0;
      score_q   <= '0;
      high_q    <= '0;
      xlife_q   <= 1'b0;
      lives_q   <= 3'(START_LIVES);
      over_q    <= 1'b0;
    end else begin
      src_q     <= src_d;
      death_q   <= death_d;
      flag_q    <= flag_d;
      dropped_q <= dropped_d;
      gcnt_q    <= gcnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      dig_q     <= dig_d;
      carry_q   <= carry_d;
      sum_q     <= sum_d;
      addend_q  <= addend_d;
      score_q   <= score_d;
      high_q    <= high_d;
      xlife_q   <= xlife_d;
      lives_q   <= lives_d;
      over_q    <= over_d;
    end
  end

  assign score_bcd = score_q;
  assign high_bcd  = high_q;
  assign lives     = lives_q;
  assign combo     = (gcnt_q == 3'd0) ? 2'd0 : 2'(gcnt_q - 3'd1);
  assign game_over = over_q;
  assign busy      = (cnt_q != '0) || (state_q != S_IDLE);
  assign dropped   = dropped_q;

`ifdef SCORE_HEX_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [7*DIGITS-1:0] hex_of(input logic [W-1:0] s);
    logic [7*DIGITS-1:0] r;
    logic lead;
    r    = '1;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (s[4*i +: 4] != 4'd0 || i == 0) lead = 1'b0;
      r[7*i +: 7] = lead ? 7'h7F : seg7(s[4*i +: 4]);
    end
    return r;
  endfunction

  logic [7*DIGITS-1:0] hex_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hex_q <= hex_of('0);
    else      hex_q <= hex_of(score_q);
  end

  assign hex = hex_q;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - directed self-checking bench for score_keeper

module tb_score_keeper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        pellet = 1'b0;
  logic        power_pellet = 1'b0;
  logic [3:0]  ghost_eaten = 4'h0;
  logic        pacman_death = 1'b0;
  logic [23:0] score_bcd, high_bcd;
  logic [2:0]  lives;
  logic [1:0]  combo;
  logic        game_over, busy, dropped;
`ifdef SCORE_HEX_EN
  logic [41:0] hex;
`endif

  int n_checks = 0;
  int n_errors = 0;

  score_keeper dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .pellet       (pellet),
    .power_pellet (power_pellet),
    .ghost_eaten  (ghost_eaten),
    .pacman_death (pacman_death),
    .score_bcd    (score_bcd),
    .high_bcd     (high_bcd),
    .lives        (lives),
    .combo        (combo),
    .game_over    (game_over),
    .busy         (busy),
    .dropped      (dropped)
`ifdef SCORE_HEX_EN
    ,
    .hex          (hex)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    cyc(1);
  endtask

  // m = {pellet, power, ghost[3:0]}, held high for exactly one clock.
  task automatic pulse(input logic [5:0] m);
    {pellet, power_pellet, ghost_eaten} = m;
    cyc(1);
    {pellet, power_pellet, ghost_eaten} = 6'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    check("drain", busy, 0);
  endtask

  task automatic pellet_one();
    pulse(6'b100000);
    cyc(2);
    drain();
  endtask

  task automatic round();
    pulse(6'b010000);
    for (int g = 0; g < 4; g++) pulse(6'b000001 << g);
    cyc(2);
  endtask

  initial begin
    logic [23:0] prev;
    logic [1:0]  combo_exp [4];
    combo_exp = '{2'd0, 2'd1, 2'd2, 2'd3};

    #2 rst = 1'b0;
    cyc(2);
    check("rst_score", score_bcd, 0);
    check("rst_high", high_bcd, 0);
    check("rst_lives", lives, 3);
    check("rst_combo", combo, 0);
    check("rst_over", game_over, 0);
    check("rst_busy", busy, 0);
    check("rst_dropped", dropped, 0);
    rst = 1'b1;
    cyc(1);

    // single pellet: score changes 9 clocks after the sampling edge
    pellet = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) pellet = 1'b0;
      if (i >= 2 && i <= 9) check("lat_busy", busy, 1);
      if (i == 9) check("lat_score_before", score_bcd, 24'h000000);
    end
    check("lat_score", score_bcd, 24'h000010);
    check("lat_idle", busy, 0);
    check("lat_lives", lives, 3);

    // power then four ghosts, spaced
    do_clear();
    pulse(6'b010000);
    cyc(1);
    check("combo_power", combo, 0);
    for (int g = 0; g < 4; g++) begin
      pulse(6'b000001 << g);
      cyc(1);
      check("combo_ghost", combo, combo_exp[g]);
    end
    drain();
    check("ghost_score", score_bcd, 24'h003050);

    // all ghosts and a pellet on the same cycle
    do_clear();
    pulse(6'b101111);
    cyc(2);
    drain();
    check("simul_score", score_bcd, 24'h003010);
    check("simul_dropped", dropped, 0);

    // extra life at the 10000 crossing, granted once
    do_clear();
    for (int r = 0; r < 3; r++) begin
      round();
      drain();
    end
    check("xl_score3", score_bcd, 24'h009150);
    check("xl_lives3", lives, 3);
    round();
    prev = score_bcd;
    for (int i = 0; i < 400 && busy; i++) begin
      @(negedge clk);
      if (score_bcd != prev) begin
        check("xl_commit", lives, (score_bcd >= 24'h010000) ? 3'd4 : 3'd3);
        prev = score_bcd;
      end
    end
    check("xl_drain", busy, 0);
    check("xl_score4", score_bcd, 24'h012200);
    check("xl_lives4", lives, 4);
    pellet_one();
    check("xl_score5", score_bcd, 24'h012210);
    check("xl_once", lives, 4);

    // deaths down to game over
    do_clear();
    for (int p = 0; p < 12; p++) pellet_one();
    check("death_score", score_bcd, 24'h000120);
    for (int d = 0; d < 3; d++) begin
      pacman_death = 1'b1;
      cyc(1);
      pacman_death = 1'b0;
      check("death_lives", lives, 3'(2 - d));
      if (d < 2) check("death_not_over", game_over, 0);
      cyc(1);
    end
    check("over_set", game_over, 1);
    check("over_high", high_bcd, 24'h000120);
    pulse(6'b100000);
    cyc(12);
    check("over_ignored", score_bcd, 24'h000120);
    check("over_idle", busy, 0);
    do_clear();
    check("clr_score", score_bcd, 0);
    check("clr_lives", lives, 3);
    check("clr_high", high_bcd, 24'h000120);
    check("clr_over", game_over, 0);

    // drop while FIFO full, then async reset mid-add
    pellet_one();
    check("pre_drop_score", score_bcd, 24'h000010);
    pulse(6'b111111);
    cyc(5);
    pellet = 1'b1;
    cyc(1);
    pellet = 1'b0;
    check("drop_set", dropped, 1);
    check("drop_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_score", score_bcd, 0);
    check("arst_high", high_bcd, 0);
    check("arst_lives", lives, 3);
    check("arst_combo", combo, 0);
    check("arst_over", game_over, 0);
    check("arst_busy", busy, 0);
    check("arst_dropped", dropped, 0);
    cyc(2);
    rst = 1'b1;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-clock-domain scoring and lives controller.
- Consumes the maze's pellet and power-pellet indications, the ghost-eaten indications and Pac-Man death.
- Produces a BCD score, a high score, a lives count and game-over status for the display/HUD path and game control.
- Serialises simultaneous scoring events through a small event FIFO and a digit-serial BCD adder.

Parameters:
DIGITS, 6, number of BCD score digits (score_bcd width = 4*DIGITS)
START_LIVES, 3, lives loaded at reset/clear
MAX_LIVES, 5, lives saturation value
EXTRA_LIFE_K, 10, extra-life threshold in thousands of points (10 = 10000)
FIFO_DEPTH, 4, scoring event FIFO entries (power of 2)

Ports:
clk  in  1  game clock
rst  in  1  reset, asynchronous, active-low
clear  in  1  synchronous new-game restart
pellet  in  1  level from maze, high while Pac-Man eats a pellet
power_pellet  in  1  level from maze, high while a power pellet is eaten
ghost_eaten  in  4  one bit per ghost: [0] blinky, [1] pinky, [2] inky, [3] clyde
pacman_death  in  1  level, high while death is signalled
score_bcd  out  4*DIGITS  current score, digit 0 in LSBs
high_bcd  out  4*DIGITS  high score
lives  out  3  remaining lives
combo  out  2  ghosts eaten since last power pellet, minus 1 (saturating)
game_over  out  1  high once lives reach 0
busy  out  1  FIFO non-empty or adder active
dropped  out  1  sticky: an event was lost

Behaviour:
- Reset (rst low): score_bcd=0, high_bcd=0, lives=START_LIVES, combo=0, game_over=0, busy=0, dropped=0, FIFO empty, all pending flags 0, FSM IDLE. Takes effect immediately, including mid-add.
- clear (sync, highest priority): same as reset except high_bcd is kept.
- Edge detect: each input is registered. A rising edge sets that source's pending flag (6 flags: ghost0..3, power, pellet).
  - While game_over=1, edges are ignored.
  - If an edge arrives while that source's flag is still set, the event is lost and dropped is set.
- Arbiter: pushes at most one flagged event per cycle when the FIFO is not full.
  - Fixed priority: ghost0, ghost1, ghost2, ghost3, power, pellet. The pushed flag clears.
- Point codes:
  - pellet = 10, power = 50.
  - ghost = 200 << k, where k is the internal ghost count (0..3, saturating at 3). The count is sampled at push, then incremented.
  - combo output = internal ghost count − 1, saturating at 0.
  - A power push resets the internal ghost count to 0.
  - A same-cycle ghost and power are handled in priority order: the ghost uses the old count.
- FIFO full: arbiter stalls and flags hold.
- Adder FSM:
  - IDLE: FIFO non-empty → pop, load addend BCD → ADD.
  - ADD: one digit per cycle, LSD first, decimal carry; DIGITS cycles → COMMIT.
  - COMMIT: score_bcd updated atomically; carry out of the MSD saturates to all 9s. Extra-life check, then → IDLE.
- Latency: with the FIFO empty and FSM IDLE, score_bcd changes DIGITS+3 clocks after the first edge at which the input is sampled high (9 clocks for DIGITS=6).
- Extra life:
  - Granted once per game, on the COMMIT where the score first becomes ≥ EXTRA_LIFE_K*1000.
  - lives += 1, saturating at MAX_LIVES.
- Death: pacman_death rising edge decrements lives, saturating at 0.
  - Reaching 0 sets game_over the next cycle.
  - Same cycle, high_bcd ← score_bcd if score_bcd > high_bcd. BCD compares as unsigned.
  - An extra life and a death on the same cycle net to no change.
- With game_over=1, events already in the FIFO still drain. high_bcd is re-evaluated at each COMMIT while game_over=1.

Optional Feature:
SCORE_HEX_EN:
- Defined: adds output hex (7*DIGITS), active-low seven-segment patterns for score_bcd, digit 0 in LSBs.
  - Leading zeros blanked; digit 0 is always shown.
  - Segments are registered, one cycle after score_bcd.
- Undefined: port and logic absent; nothing else changes.

Test Plan:
- Single pellet pulse (1 cycle high) from reset → score_bcd=000010 exactly 9 clocks later; busy high in between; lives=3.
- Power pellet, then ghosts 0,1,2,3 on separate cycles → final score 003050; combo sequence 0,0,1,2,3.
- Same cycle: all four ghost_eaten bits + pellet high → final score 003010, pushed in priority order; dropped=0.
- Four power+4-ghost rounds (12200 points) → lives 3→4 exactly once, at the COMMIT crossing 10000; no further increment.
- Three death pulses with score 000120 → lives 2,1,0; game_over=1; high_bcd=000120. Later pellet is ignored; clear → score 0, lives 3, high_bcd kept.
- rst low during ADD → all outputs immediately at reset values, including high_bcd=0. Pellet re-toggled twice before its push while the FIFO is full → dropped=1.
